sram_sp_access_ctrl: RTL
========================

// Module: sram_sp_access_ctrl
// PURPOSE
//  Request/response front end for one single-port SRAM macro (CEB/WEB active-low, 1-cycle read, Q undefined when not reading).
//  Arbitrates a write channel and a read channel onto the single port, at most one access per cycle.
//  Captures read data into an in-order response buffer with valid/ready backpressure, so consumers never sample raw Q.
// PARAMETERS
//  DATA_W      128  data width; equals macro Bits
//  DEPTH       16   words in macro
//  ADDR_W      4    address width, log2(DEPTH)
//  RESP_DEPTH  3    response buffer entries (>=2); 3 sustains 1 read/cycle
//  WR_PRIO     1    1: write wins a same-cycle conflict; 0: read wins
// PORTS
//  clock       in   1       clock, all state on posedge
//  reset_n     in   1       synchronous reset, active-low
//  wr_valid    in   1       write request
//  wr_ready    out  1       write accepted when wr_valid&&wr_ready
//  wr_addr     in   ADDR_W  write address
//  wr_data     in   DATA_W  write data
//  rd_valid    in   1       read request
//  rd_ready    out  1       read accepted when rd_valid&&rd_ready
//  rd_addr     in   ADDR_W  read address
//  resp_valid  out  1       response buffer head valid
//  resp_ready  in   1       consumer pops head when resp_valid&&resp_ready
//  resp_data   out  DATA_W  head read data
//  init_done   out  1       controller accepting requests
//  sram_ceb    out  1       macro chip enable, active-low
//  sram_web    out  1       macro write enable, active-low (0=write)
//  sram_a      out  ADDR_W  macro address
//  sram_d      out  DATA_W  macro write data
//  sram_q      in   DATA_W  macro read data, valid the cycle after a read
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): buffer emptied, in-flight read dropped, counters 0; resp_valid=0, wr_ready=rd_ready=0.
//  - States: INIT (macro builds only), RUN. Without the macro, RUN from the first cycle after reset; init_done=1 in RUN.
//  - credit_ok = (buf_occ + inflight) < RESP_DEPTH, both registered; pops in the same cycle are not counted.
//  - RUN arbitration (combinational): WR_PRIO=1: wr_ready=1; rd_ready=credit_ok&&!wr_valid.
//    WR_PRIO=0: rd_ready=credit_ok; wr_ready=!(rd_valid&&credit_ok).
//  - SRAM drive (combinational from fire): write fire: ceb=0, web=0, a=wr_addr, d=wr_data.
//    Read fire: ceb=0, web=1, a=rd_addr. Idle: ceb=1, web=1, a=0, d=0.
//  - Read latency: fire at edge t; sram_q sampled at edge t+1 into buffer tail; resp_valid=1 from t+1 (2 cycles after request cycle).
//  - inflight: 1-bit reg, set on read fire, cleared on capture; a read fire may coincide with a capture (pipelined).
//  - Buffer: FIFO, pointers wrap modulo RESP_DEPTH; push and pop in one cycle allowed; overflow impossible by credit rule.
//  - resp_data is the head entry; held stable while resp_valid&&!resp_ready.
//  - Responses return strictly in request order.
//  - Write then read of the same address in a later cycle returns the new data (macro writes at the edge).
//  - Same-cycle write+read: only the priority side fires; the loser stalls and its inputs stay asserted.
//  - Reset mid-operation: pending responses are discarded; no stale response appears after reset releases.
// CONFIGURATION
//  SRAM_ZERO_INIT_EN defined: after reset, enter INIT and write 0 to addresses 0..DEPTH-1, one per cycle
//    (ceb=0, web=0, d=0, a=counter). During INIT: wr_ready=rd_ready=0, init_done=0.
//    The cycle after the last write enters RUN with init_done=1. Reset during INIT restarts at address 0.
//  Not defined: no INIT state; macro contents are undefined until written.
// TESTING
//  1. Write 0xA5..A5 to addr 3, read addr 3 next cycle -> resp_valid 2 cycles after read fire, resp_data=0xA5..A5.
//  2. resp_ready=1, 16 reads addr 0..15 back-to-back -> rd_ready stays 1, 16 consecutive in-order responses, no bubbles.
//  3. resp_ready=0, continuous reads -> exactly 3 accepted, rd_ready=0 thereafter, sram_ceb=1.
//     Release resp_ready -> 3 in-order responses.
//  4. WR_PRIO=1, wr+rd same cycle to addr 5 (old 0x1, new 0x2) -> write fires, read fires next cycle, returns 0x2.
//     WR_PRIO=0 -> read fires first, returns 0x1.
//  5. Reset pulse with 1 read in flight and 2 buffered -> resp_valid=0 from the cycle after reset; no response until a new read.
//  6. SRAM_ZERO_INIT_EN, DEPTH=16 -> sram_ceb=0 for 16 cycles at a=0..15, init_done rises after the last write,
//     reads of all addresses return 0.

Source files
------------

// File: rtl/sram_sp_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_access_ctrl_if
// Brief    : Request, response and macro-side bundle for sram_sp_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_sp_access_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  // Controller side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
    output wr_ready, rd_ready, resp_valid, resp_data, init_done,
           sram_ceb, sram_web, sram_a, sram_d
  );

  // Requester plus macro side.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
    input  wr_ready, rd_ready, resp_valid, resp_data, init_done,
           sram_ceb, sram_web, sram_a, sram_d
  );
endinterface
`default_nettype wire

// File: rtl/sram_sp_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_access_ctrl
// Brief    : Single-port SRAM front end: write/read arbitration plus an in-order
//            response FIFO. Build option SRAM_ZERO_INIT_EN zero-fills the macro.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp_access_ctrl #(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int RESP_DEPTH = 3,
  parameter bit WR_PRIO    = 1'b1
) (
  input wire                   clock,
  input wire                   reset_n,
  sram_sp_access_ctrl_if.slave bus
);

  localparam int               PTR_W      = $clog2(RESP_DEPTH);
  localparam int               OCC_W      = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
  localparam logic [OCC_W:0]   CREDIT_MAX = (OCC_W + 1)'(RESP_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  if (RESP_DEPTH < 2 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_param_check
    $error("sram_sp_access_ctrl: inconsistent DEPTH/ADDR_W/RESP_DEPTH");
  end

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] resp_mem_q [RESP_DEPTH];

  logic              run;
  logic              credit_ok;
  logic [OCC_W:0]    committed;
  logic              wr_ready;
  logic              rd_ready;
  logic              wr_fire;
  logic              rd_fire;
  logic              capture;
  logic              pop;
  logic              init_active;
  logic              init_last;
  logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_ZERO_INIT_EN
  localparam state_t            RESET_STATE = ST_INIT;
  localparam logic [ADDR_W-1:0] INIT_LAST   = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] init_addr_q, init_addr_d;

  assign init_active = reset_n && (state_q == ST_INIT);
  assign init_last   = (init_addr_q == INIT_LAST);
  assign init_addr   = init_addr_q;

  always_comb begin
    init_addr_d = init_addr_q;
    if (init_active) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_addr_q <= '0;
    end else begin
      init_addr_q <= init_addr_d;
    end
  end
`else
  localparam state_t RESET_STATE = ST_RUN;

  assign init_active = 1'b0;
  assign init_last   = 1'b0;
  assign init_addr   = '0;
`endif

  // Requests are refused while reset is held so nothing reaches the macro.
  assign run       = reset_n && (state_q == ST_RUN);
  assign committed = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
  assign credit_ok = (committed < CREDIT_MAX);

  if (WR_PRIO) begin : g_wr_prio
    assign wr_ready = run;
    assign rd_ready = run && credit_ok && !bus.wr_valid;
  end else begin : g_rd_prio
    assign rd_ready = run && credit_ok;
    assign wr_ready = run && !(bus.rd_valid && credit_ok);
  end

  assign wr_fire = bus.wr_valid && wr_ready;
  assign rd_fire = bus.rd_valid && rd_ready;
  assign capture = inflight_q;
  assign pop     = bus.resp_valid && bus.resp_ready;

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_ready   = rd_ready;
  assign bus.init_done  = run;
  assign bus.resp_valid = (occ_q != '0);
  assign bus.resp_data  = resp_mem_q[head_q];

  always_comb begin
    bus.sram_ceb = 1'b1;
    bus.sram_web = 1'b1;
    bus.sram_a   = '0;
    bus.sram_d   = '0;
    if (init_active) begin
      bus.sram_ceb = 1'b0;
      bus.sram_web = 1'b0;
      bus.sram_a   = init_addr;
    end else if (wr_fire) begin
      bus.sram_ceb = 1'b0;
      bus.sram_web = 1'b0;
      bus.sram_a   = bus.wr_addr;
      bus.sram_d   = bus.wr_data;
    end else if (rd_fire) begin
      bus.sram_ceb = 1'b0;
      bus.sram_a   = bus.rd_addr;
    end
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A new read may launch in the same cycle the previous one is captured.
  always_comb begin
    state_d    = state_q;
    inflight_d = rd_fire;
    head_d     = pop ? ptr_next(head_q) : head_q;
    tail_d     = capture ? ptr_next(tail_q) : tail_q;
    occ_d      = occ_q;
    case ({capture, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (init_active && init_last) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      resp_mem_q[tail_q] <= bus.sram_q;
    end
  end

endmodule
`default_nettype wire
